// File: rtl/ncejdtm200_pkg.sv
// Shared DMI definitions: word layout, op codes and arbiter state encoding.
package ncejdtm200_pkg;

   localparam int unsigned DMI_DATA_BITS = 32;
   localparam int unsigned DMI_OP_BITS   = 2;
   localparam int unsigned DMI_ADDR_BITS_DEF = 7;

   localparam logic [DMI_OP_BITS-1:0] DMI_OP_NOP   = 2'd0;
   localparam logic [DMI_OP_BITS-1:0] DMI_OP_READ  = 2'd1;
   localparam logic [DMI_OP_BITS-1:0] DMI_OP_WRITE = 2'd2;
   localparam logic [DMI_OP_BITS-1:0] DMI_OP_RSV   = 2'd3;

   // Word layout {addr, data, op}; addr sits above the fixed-width fields.
   localparam int unsigned DMI_OP_LSB   = 0;
   localparam int unsigned DMI_DATA_LSB = DMI_OP_LSB + DMI_OP_BITS;
   localparam int unsigned DMI_ADDR_LSB = DMI_DATA_LSB + DMI_DATA_BITS;

   function automatic int unsigned dmi_reg_bits(input int unsigned addr_bits);
      return DMI_ADDR_LSB + addr_bits;
   endfunction

   localparam int unsigned DMI_REG_BITS_DEF = DMI_ADDR_LSB + DMI_ADDR_BITS_DEF;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_ISSUE   = 2'd1,
      ARB_RELEASE = 2'd2,
      ARB_RESPOND = 2'd3
   } arb_state_e;

endpackage

// File: rtl/ncejdtm200_dmi_arb_if.sv
// Requester-side and DMI-master-side handshake bundle of the DMI arbiter.
interface ncejdtm200_dmi_arb_if
   import ncejdtm200_pkg::*;
#(
   parameter int unsigned N_REQ        = 2,
   parameter int unsigned DMI_REG_BITS = DMI_REG_BITS_DEF
);
   logic [N_REQ-1:0]              req_dmi_req;
   logic [N_REQ*DMI_REG_BITS-1:0] req_dmi_data;
   logic [N_REQ-1:0]              dmi_req_ack;
   logic [DMI_DATA_BITS-1:0]      dmi_req_rdata;
   logic                          dmi_req_err;
   logic                          arb_dmi_req;
   logic [DMI_REG_BITS-1:0]       arb_dmi_data;
   logic                          dmi_arb_ack;
   logic [DMI_DATA_BITS-1:0]      dmi_arb_hrdata;

   // Arbiter view.
   modport master (
      input  req_dmi_req, req_dmi_data, dmi_arb_ack, dmi_arb_hrdata,
      output dmi_req_ack, dmi_req_rdata, dmi_req_err, arb_dmi_req, arb_dmi_data
   );

   // Environment view: requesters plus the DMI master.
   modport slave (
      output req_dmi_req, req_dmi_data, dmi_arb_ack, dmi_arb_hrdata,
      input  dmi_req_ack, dmi_req_rdata, dmi_req_err, arb_dmi_req, arb_dmi_data
   );
endinterface

// File: rtl/ncejdtm200_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module ncejdtm200_rr_pick
   import ncejdtm200_pkg::*;
#(
   parameter  int unsigned N_REQ = 2,
   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] index
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      valid = 1'b0;
      index = '0;
      cand  = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = IDX_W'((32'(ptr) + k) % N_REQ);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/ncejdtm200_dmi_arb.sv
// Round-robin arbiter sharing one DMI master port between N debug requesters,
// with a per-transaction ISSUE timeout that returns an error to the requester.
module ncejdtm200_dmi_arb
   import ncejdtm200_pkg::*;
#(
   parameter int unsigned N_REQ          = 2,
   parameter int unsigned DMI_ADDR_BITS  = DMI_ADDR_BITS_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input logic                  dmi_hclk,
   input logic                  dmi_hresetn,
   ncejdtm200_dmi_arb_if.master bus
);

   localparam int unsigned DMI_REG_BITS = dmi_reg_bits(DMI_ADDR_BITS);
   localparam int unsigned IDX_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CNT_W        = $clog2(TIMEOUT_CYCLES);

   arb_state_e       state;
   logic [IDX_W-1:0] grant;
   logic [IDX_W-1:0] rr_ptr;
   logic [CNT_W-1:0] cnt;

   logic             pick_valid_c;
   logic [IDX_W-1:0] pick_idx_c;

   ncejdtm200_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req   (bus.req_dmi_req),
      .ptr   (rr_ptr),
      .valid (pick_valid_c),
      .index (pick_idx_c)
   );

   always_ff @(posedge dmi_hclk) begin
      if (!dmi_hresetn) begin
         state             <= ARB_IDLE;
         grant             <= '0;
         rr_ptr            <= '0;
         cnt               <= '0;
         bus.arb_dmi_req   <= 1'b0;
         bus.arb_dmi_data  <= '0;
         bus.dmi_req_ack   <= '0;
         bus.dmi_req_rdata <= '0;
         bus.dmi_req_err   <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_valid_c) begin
                  grant            <= pick_idx_c;
                  bus.arb_dmi_data <= bus.req_dmi_data[pick_idx_c*DMI_REG_BITS +: DMI_REG_BITS];
                  cnt              <= '0;
                  bus.arb_dmi_req  <= 1'b1;
                  state            <= ARB_ISSUE;
               end
            end
            // Ack beats the timeout when both land in the same cycle.
            ARB_ISSUE: begin
               if (bus.dmi_arb_ack) begin
                  bus.dmi_req_rdata <= bus.dmi_arb_hrdata;
                  bus.dmi_req_err   <= 1'b0;
                  bus.arb_dmi_req   <= 1'b0;
                  state             <= ARB_RELEASE;
               end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  bus.dmi_req_rdata <= '0;
                  bus.dmi_req_err   <= 1'b1;
                  bus.arb_dmi_req   <= 1'b0;
                  state             <= ARB_RELEASE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ARB_RELEASE: begin
               if (!bus.dmi_arb_ack) begin
                  bus.dmi_req_ack <= N_REQ'(1) << grant;
                  state           <= ARB_RESPOND;
               end
            end
            ARB_RESPOND: begin
               if (!bus.req_dmi_req[grant]) begin
                  bus.dmi_req_ack <= '0;
                  rr_ptr          <= (grant == IDX_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
                  state           <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ncejdtm200_dmi_arb.sv
// Directed bench for the DMI arbiter: N_REQ=2, TIMEOUT_CYCLES=16.
module tb_ncejdtm200_dmi_arb;

   localparam int unsigned NR   = 2;
   localparam int unsigned AW   = 7;
   localparam int unsigned RB   = 32 + AW + 2;
   localparam logic [RB-1:0] W0 = {7'h10, 32'h0000_0000, 2'd1};
   localparam logic [RB-1:0] W1 = {7'h11, 32'h0000_1111, 2'd2};

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   ncejdtm200_dmi_arb_if #(.N_REQ(NR), .DMI_REG_BITS(RB)) bus ();

   ncejdtm200_dmi_arb #(.N_REQ(NR), .DMI_ADDR_BITS(AW), .TIMEOUT_CYCLES(16)) dut (
      .dmi_hclk    (clk),
      .dmi_hresetn (rst_n),
      .bus         (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if (bus.arb_dmi_req !== 1'b0) begin errors++; $display("FAIL reset_arb_req got %0h exp 0", bus.arb_dmi_req); end
      checks++; if (bus.arb_dmi_data !== '0) begin errors++; $display("FAIL reset_arb_data got %0h exp 0", bus.arb_dmi_data); end
      checks++; if (bus.dmi_req_ack !== 2'b00) begin errors++; $display("FAIL reset_ack got %b exp 00", bus.dmi_req_ack); end
      checks++; if (bus.dmi_req_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", bus.dmi_req_rdata); end
      checks++; if (bus.dmi_req_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0h exp 0", bus.dmi_req_err); end
      checks++; if (dut.state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dut.state); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_read();
      bus.req_dmi_req = 2'b01;
      tick();
      checks++; if (bus.arb_dmi_req !== 1'b1) begin errors++; $display("FAIL read_issue got %0h exp 1", bus.arb_dmi_req); end
      checks++; if (bus.arb_dmi_data !== W0) begin errors++; $display("FAIL read_word got %h exp %h", bus.arb_dmi_data, W0); end
      repeat (4) tick();
      checks++; if (bus.arb_dmi_req !== 1'b1) begin errors++; $display("FAIL read_hold_req got %0h exp 1", bus.arb_dmi_req); end
      bus.dmi_arb_ack = 1'b1;
      bus.dmi_arb_hrdata = 32'hDEAD_BEEF;
      tick();
      checks++; if (bus.arb_dmi_req !== 1'b0) begin errors++; $display("FAIL read_release_req got %0h exp 0", bus.arb_dmi_req); end
      checks++; if (bus.dmi_req_ack !== 2'b00) begin errors++; $display("FAIL read_early_ack got %b exp 00", bus.dmi_req_ack); end
      bus.dmi_arb_ack = 1'b0;
      bus.dmi_arb_hrdata = 32'h0;
      tick();
      checks++; if (bus.dmi_req_ack !== 2'b01) begin errors++; $display("FAIL read_ack got %b exp 01", bus.dmi_req_ack); end
      checks++; if (bus.dmi_req_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_rdata got %h exp deadbeef", bus.dmi_req_rdata); end
      checks++; if (bus.dmi_req_err !== 1'b0) begin errors++; $display("FAIL read_err got %0h exp 0", bus.dmi_req_err); end
      tick();
      checks++; if (bus.dmi_req_ack !== 2'b01) begin errors++; $display("FAIL read_ack_hold got %b exp 01", bus.dmi_req_ack); end
      bus.req_dmi_req = 2'b00;
      tick();
      checks++; if (bus.dmi_req_ack !== 2'b00) begin errors++; $display("FAIL read_ack_clear got %b exp 00", bus.dmi_req_ack); end
   endtask

   task automatic test_timeout();
      int n;
      n = 0;
      bus.req_dmi_req = 2'b01;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.arb_dmi_req) n++;
         else if (n > 0) break;
      end
      checks++; if (n != 16) begin errors++; $display("FAIL timeout_req_cycles got %0d exp 16", n); end
      tick();
      checks++; if (bus.dmi_req_ack !== 2'b01) begin errors++; $display("FAIL timeout_ack got %b exp 01", bus.dmi_req_ack); end
      checks++; if (bus.dmi_req_err !== 1'b1) begin errors++; $display("FAIL timeout_err got %0h exp 1", bus.dmi_req_err); end
      checks++; if (bus.dmi_req_rdata !== 32'h0) begin errors++; $display("FAIL timeout_rdata got %h exp 0", bus.dmi_req_rdata); end
      bus.req_dmi_req = 2'b00;
      tick();
   endtask

   task automatic test_ack_boundary();
      bus.req_dmi_req = 2'b10;
      tick();
      checks++; if (bus.arb_dmi_data !== W1) begin errors++; $display("FAIL bound_word got %h exp %h", bus.arb_dmi_data, W1); end
      repeat (15) tick();
      checks++; if (bus.arb_dmi_req !== 1'b1) begin errors++; $display("FAIL bound_req got %0h exp 1", bus.arb_dmi_req); end
      checks++; if (dut.cnt !== 4'd15) begin errors++; $display("FAIL bound_cnt got %0d exp 15", dut.cnt); end
      bus.dmi_arb_ack = 1'b1;
      bus.dmi_arb_hrdata = 32'h1234_5678;
      tick();
      checks++; if (bus.arb_dmi_req !== 1'b0) begin errors++; $display("FAIL bound_release got %0h exp 0", bus.arb_dmi_req); end
      bus.dmi_arb_ack = 1'b0;
      tick();
      checks++; if (bus.dmi_req_ack !== 2'b10) begin errors++; $display("FAIL bound_ack got %b exp 10", bus.dmi_req_ack); end
      checks++; if (bus.dmi_req_err !== 1'b0) begin errors++; $display("FAIL bound_err got %0h exp 0", bus.dmi_req_err); end
      checks++; if (bus.dmi_req_rdata !== 32'h1234_5678) begin errors++; $display("FAIL bound_rdata got %h exp 12345678", bus.dmi_req_rdata); end
      bus.req_dmi_req = 2'b00;
      tick();
   endtask

   task automatic test_early_drop();
      bus.req_dmi_req = 2'b10;
      tick();
      tick();
      bus.req_dmi_req = 2'b00;
      tick();
      tick();
      bus.dmi_arb_ack = 1'b1;
      bus.dmi_arb_hrdata = 32'hA5A5_A5A5;
      tick();
      checks++; if (bus.arb_dmi_req !== 1'b0) begin errors++; $display("FAIL drop_release got %0h exp 0", bus.arb_dmi_req); end
      bus.dmi_arb_ack = 1'b0;
      tick();
      checks++; if (bus.dmi_req_ack !== 2'b10) begin errors++; $display("FAIL drop_ack got %b exp 10", bus.dmi_req_ack); end
      checks++; if (bus.dmi_req_rdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL drop_rdata got %h exp a5a5a5a5", bus.dmi_req_rdata); end
      tick();
      checks++; if (bus.dmi_req_ack !== 2'b00) begin errors++; $display("FAIL drop_ack_pulse got %b exp 00", bus.dmi_req_ack); end
      checks++; if (dut.state !== 2'd0) begin errors++; $display("FAIL drop_state got %0d exp 0", dut.state); end
      repeat (2) tick();
      checks++; if (bus.arb_dmi_req !== 1'b0) begin errors++; $display("FAIL drop_no_reissue got %0h exp 0", bus.arb_dmi_req); end
   endtask

   task automatic test_contention();
      int n;
      int e;
      bus.req_dmi_req = 2'b11;
      tick();
      for (int r = 0; r < 6; r++) begin
         e = r % 2;
         n = 0;
         while (!bus.arb_dmi_req && n < 8) begin
            tick();
            n++;
         end
         checks++; if (bus.arb_dmi_req !== 1'b1) begin errors++; $display("FAIL cont_req round %0d got %0h exp 1", r, bus.arb_dmi_req); end
         checks++; if (bus.arb_dmi_data !== (e == 1 ? W1 : W0)) begin errors++; $display("FAIL cont_grant round %0d got %h exp %h", r, bus.arb_dmi_data, (e == 1 ? W1 : W0)); end
         bus.dmi_arb_ack = 1'b1;
         bus.dmi_arb_hrdata = 32'hC0DE_0000 + 32'(r);
         tick();
         bus.dmi_arb_ack = 1'b0;
         tick();
         checks++; if (bus.dmi_req_ack !== (e == 1 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cont_ack round %0d got %b exp %b", r, bus.dmi_req_ack, (e == 1 ? 2'b10 : 2'b01)); end
         checks++; if (bus.dmi_req_rdata !== 32'hC0DE_0000 + 32'(r)) begin errors++; $display("FAIL cont_rdata round %0d got %h", r, bus.dmi_req_rdata); end
         bus.req_dmi_req[e] = 1'b0;
         tick();
         checks++; if (bus.dmi_req_ack !== 2'b00) begin errors++; $display("FAIL cont_ack_clear round %0d got %b exp 00", r, bus.dmi_req_ack); end
         bus.req_dmi_req[e] = 1'b1;
      end
      bus.req_dmi_req = 2'b00;
      tick();
   endtask

   task automatic test_reset_release();
      bus.req_dmi_req = 2'b01;
      tick();
      bus.dmi_arb_ack = 1'b1;
      tick();
      bus.dmi_arb_ack = 1'b0;
      tick();
      bus.req_dmi_req = 2'b00;
      tick();
      bus.req_dmi_req = 2'b01;
      tick();
      bus.dmi_arb_ack = 1'b1;
      bus.dmi_arb_hrdata = 32'h0000_0055;
      tick();
      checks++; if (dut.state !== 2'd2) begin errors++; $display("FAIL rst_pre_state got %0d exp 2", dut.state); end
      rst_n = 1'b0;
      tick();
      checks++; if (bus.arb_dmi_req !== 1'b0) begin errors++; $display("FAIL rst_arb_req got %0h exp 0", bus.arb_dmi_req); end
      checks++; if (bus.arb_dmi_data !== '0) begin errors++; $display("FAIL rst_arb_data got %h exp 0", bus.arb_dmi_data); end
      checks++; if (bus.dmi_req_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.dmi_req_rdata); end
      checks++; if (bus.dmi_req_ack !== 2'b00) begin errors++; $display("FAIL rst_ack got %b exp 00", bus.dmi_req_ack); end
      checks++; if (dut.state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", dut.state); end
      checks++; if (dut.rr_ptr !== 1'b0) begin errors++; $display("FAIL rst_ptr got %0d exp 0", dut.rr_ptr); end
      rst_n = 1'b1;
      bus.dmi_arb_ack = 1'b0;
      bus.req_dmi_req = 2'b00;
      tick();
      bus.req_dmi_req = 2'b11;
      tick();
      checks++; if (bus.arb_dmi_req !== 1'b1) begin errors++; $display("FAIL rst_serve_req got %0h exp 1", bus.arb_dmi_req); end
      checks++; if (bus.arb_dmi_data !== W0) begin errors++; $display("FAIL rst_serve_grant got %h exp %h", bus.arb_dmi_data, W0); end
      bus.dmi_arb_ack = 1'b1;
      bus.dmi_arb_hrdata = 32'h0000_600D;
      tick();
      bus.dmi_arb_ack = 1'b0;
      tick();
      checks++; if (bus.dmi_req_ack !== 2'b01) begin errors++; $display("FAIL rst_serve_ack got %b exp 01", bus.dmi_req_ack); end
      checks++; if (bus.dmi_req_rdata !== 32'h0000_600D) begin errors++; $display("FAIL rst_serve_rdata got %h exp 600d", bus.dmi_req_rdata); end
      bus.req_dmi_req = 2'b00;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.req_dmi_req = '0;
      bus.req_dmi_data = {W1, W0};
      bus.dmi_arb_ack = 1'b0;
      bus.dmi_arb_hrdata = '0;
      test_reset();
      test_single_read();
      test_timeout();
      test_ack_boundary();
      test_early_drop();
      test_contention();
      test_reset_release();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
